// File: rtl/data_bus_arbiter_pkg.sv
// Shared widths, FSM encodings and request bundle type for the data-port arbiter.
// Width macros are guarded so a project-wide defines header may override them.
`ifndef DATA_BUS_ARB_DEFINES
`define DATA_BUS_ARB_DEFINES
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_TRANSFER_WIDTH
`define MEM_TRANSFER_WIDTH 4
`endif
`define ARB_ID_WIDTH 1
`define ARB_ST_ARB  1'b0
`define ARB_ST_LOCK 1'b1
`endif

package data_bus_arbiter_pkg;

    localparam int ADDR_W = `MEM_ADDR_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;
    localparam int BE_W   = `MEM_TRANSFER_WIDTH;
    localparam int ID_W   = `ARB_ID_WIDTH;

    localparam logic [0:0] ST_ARB  = `ARB_ST_ARB;
    localparam logic [0:0] ST_LOCK = `ARB_ST_LOCK;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/data_bus_arbiter_id_fifo.sv
// In-order FIFO of granted port IDs, one entry per outstanding memory transfer.
// Same-cycle push and pop are allowed; push on full / pop on empty are ignored.
module data_arb_id_fifo
    import data_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head_id,
    output logic            full,
    output logic            empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// 2:1 req/gnt arbiter for the data RAM port (0-cycle request and response paths).
// Optional macro DATA_ARB_RR_EN selects round-robin; default is fixed priority to port 0.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic              p0_wr_i,
    input  logic [BE_W-1:0]   p0_be_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_wr_i,
    input  logic [BE_W-1:0]   p1_be_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              m_req_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic              m_wr_o,
    output logic [BE_W-1:0]   m_be_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic              m_gnt_i,
    input  logic              m_rvalid_i,
    input  logic [DATA_W-1:0] m_rdata_i,
    output logic              err_o
);

    logic [0:0]      state;
    logic [ID_W-1:0] lock_id;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] head_id;
    logic            fifo_full;
    logic            fifo_empty;
    logic            m_act;
    logic            gnt;
    logic            rsp;
    req_t            p0_r;
    req_t            p1_r;
    req_t            m_r;

    assign p0_r = '{addr: p0_addr_i, wr: p0_wr_i, be: p0_be_i, wdata: p0_wdata_i};
    assign p1_r = '{addr: p1_addr_i, wr: p1_wr_i, be: p1_be_i, wdata: p1_wdata_i};

`ifdef DATA_ARB_RR_EN
    // prio names the port that wins a tie; the granted port drops to lowest priority
    logic [ID_W-1:0] prio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   prio <= '0;
        else if (gnt) prio <= ~sel;
    end

    always_comb begin
        winner = p0_req_i ? 1'b0 : 1'b1;
        if (p0_req_i && p1_req_i) winner = prio;
    end
`else
    assign winner = p0_req_i ? 1'b0 : 1'b1;
`endif

    // A full FIFO only masks new arbitration; LOCK was entered with a slot free
    assign sel   = (state == ST_LOCK) ? lock_id : winner;
    assign m_act = (state == ST_LOCK) || (!fifo_full && (p0_req_i || p1_req_i));
    assign m_r   = !m_act ? '0 : ((sel == 1'b0) ? p0_r : p1_r);

    assign m_req_o   = m_act;
    assign m_addr_o  = m_r.addr;
    assign m_wr_o    = m_r.wr;
    assign m_be_o    = m_r.be;
    assign m_wdata_o = m_r.wdata;

    assign gnt      = m_act && m_gnt_i;
    assign p0_gnt_o = gnt && (sel == 1'b0);
    assign p1_gnt_o = gnt && (sel == 1'b1);

    assign rsp         = m_rvalid_i && !fifo_empty;
    assign p0_rvalid_o = rsp && (head_id == 1'b0);
    assign p1_rvalid_o = rsp && (head_id == 1'b1);
    assign p0_rdata_o  = p0_rvalid_o ? m_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? m_rdata_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ARB;
            lock_id <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (m_act && !m_gnt_i) begin
                        state   <= ST_LOCK;
                        lock_id <= winner;
                    end
                end
                ST_LOCK: begin
                    if (m_gnt_i) state <= ST_ARB;
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        err_o <= 1'b0;
        else if (m_rvalid_i && fifo_empty) err_o <= 1'b1;
    end

    data_arb_id_fifo #(
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (gnt),
        .push_id (sel),
        .pop     (m_rvalid_i),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
